variable_node_unit: RTL and testbench
=====================================

VARIABLE_NODE_UNIT -- requirements
Module: variable_node_unit

Interface
REQ-001 SHALL have parameter DV, default 4, meaning variable-node degree (check messages per node), legal range 2..8.
REQ-002 SHALL have parameter W, default 16, meaning message width in sign-magnitude (bit W-1 = sign, 1 = negative; bits W-2:0 = magnitude).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins one node update; sampled only in IDLE.
REQ-006 SHALL have port ch_llr, input, W bits: channel LLR (sign-magnitude), captured on the cycle start is accepted.
REQ-007 SHALL have ports msg_valid (input, 1), msg_ready (output, 1) and msg_data (input, W): serial check-to-variable messages Rcv.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, W) and out_last (output, 1): serial variable-to-check messages Lvc.
REQ-009 SHALL have ports hard_bit (output, 1), meaning the decoded bit, and busy (output, 1), meaning the block is not in IDLE.

Function
REQ-010 SHALL implement the states IDLE, ACCUM and EMIT.
REQ-011 IDLE->ACCUM on start=1: capture ch_llr and clear the edge counter; busy=1 the following cycle.
REQ-012 In ACCUM, msg_ready SHALL be 1; msg_ready SHALL be 0 in IDLE and EMIT.
REQ-013 A message transfer SHALL occur only when msg_valid and msg_ready are both 1.
REQ-014 Message k (k = 0..DV-1, in arrival order) SHALL be stored in an internal buffer and added to the accumulator.
REQ-015 On the DV-th transfer, the state SHALL go ACCUM->EMIT on the next edge; hard_bit SHALL update on that same edge.
REQ-016 Inputs SHALL be converted sign-magnitude -> two's complement (value = sign ? -mag : mag); 0x8000 (negative zero) SHALL be treated as 0.
REQ-017 The accumulator SHALL be W+4 bits two's complement, holding L = ch_llr + sum of Rcv_k with no internal overflow.
REQ-018 hard_bit SHALL be 1 iff L<0, and 0 when L=0.
REQ-019 In EMIT, the block SHALL output, in edge order k = 0..DV-1, Lvc_k = L - Rcv_k.
REQ-020 Each Lvc_k SHALL be saturated to [-(2^(W-1)-1), +(2^(W-1)-1)] and converted to sign-magnitude; zero SHALL be output as 0x0000.
REQ-021 out_valid SHALL be registered and SHALL assert the first cycle in EMIT.
REQ-022 An output transfer SHALL occur when out_valid and out_ready are both 1; the next edge then presents edge k+1, so throughput is 1 per cycle with out_ready held high.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-024 out_last SHALL be 1 only with edge DV-1.
REQ-025 After the last transfer: EMIT->IDLE, with out_valid=0 and busy=0 on the next cycle.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 msg_valid SHALL be ignored outside ACCUM.
REQ-028 hard_bit SHALL hold until the next EMIT entry.
REQ-029 Start-to-first-out_valid latency SHALL be DV+1 cycles with msg_valid held high.

Reset
REQ-030 While rst=0, and asynchronously on its assertion, the block SHALL force: state=IDLE; msg_ready=0, out_valid=0, out_last=0, out_data=0, hard_bit=0, busy=0; accumulator, counter and buffer cleared.
REQ-031 Reset mid-ACCUM or mid-EMIT SHALL discard the partial update; no output transfer SHALL occur until a new start.

Verification
REQ-032 ch 0x000A, msgs 0x0001/0x0002/0x0003/0x0004, out_ready=1 -> out_data 0x0013, 0x0012, 0x0011, 0x0010; out_last on the 4th; hard_bit=0; first out_valid 5 cycles after start.
REQ-033 ch 0x8005, msgs 0x8003/0x0002/0x8001/0x0000 -> L=-7; outputs 0x8004, 0x8009, 0x8006, 0x8007; hard_bit=1.
REQ-034 ch 0x7FFF with four msgs 0x7FFF -> all outputs 0x7FFF, hard_bit=0; ch 0xFFFF with four msgs 0xFFFF -> all outputs 0xFFFF, hard_bit=1.
REQ-035 Case REQ-032 with out_ready=0 for 3 cycles while edge 1 is presented -> 0x0012 held stable, no loss or duplication, 4 transfers total.
REQ-036 Case REQ-032 with msg_valid gaps and start pulsed during ACCUM -> identical outputs; the extra start is ignored.
REQ-037 rst=0 after 2 messages accepted -> all outputs 0 immediately; a new run of REQ-033 then yields exact results.
REQ-038 ch 0x8000 with msgs 0x0000/0x8000/0x0000/0x0000 -> outputs all 0x0000, hard_bit=0.

Source files
------------

// File: rtl/variable_node_unit_if.sv
// Message channels of the variable node unit.
//   msg_*  : serial check-to-variable messages (Rcv) into the node
//   out_*  : serial variable-to-check messages (Lvc) out of the node
// slave modport is the node side; master modport is the driver/consumer side.
interface variable_node_unit_if #(
    parameter int W = 16
) ();
    logic         msg_valid;
    logic         msg_ready;
    logic [W-1:0] msg_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport slave (
        input  msg_valid,
        input  msg_data,
        output msg_ready,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport master (
        output msg_valid,
        output msg_data,
        input  msg_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/variable_node_unit.sv
// LDPC variable node update.
// Accumulates L = ch_llr + sum(Rcv_k) over DV serial messages, then emits
// Lvc_k = L - Rcv_k for k = 0..DV-1, saturated and in sign-magnitude.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   start        : begin one node update (sampled in IDLE only)
//   ch_llr       : channel LLR, sign-magnitude, captured with start
//   bus          : msg (Rcv in) and out (Lvc out) valid/ready channels
//   hard_bit     : decoded bit, 1 when L < 0
//   busy         : block is not in IDLE
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting DV check messages into buffer and accumulator
// EMIT  | presenting DV extrinsic messages, one per out transfer
module variable_node_unit #(
    parameter int DV = 4,
    parameter int W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         ch_llr,
    variable_node_unit_if.slave  bus,
    output logic                 hard_bit,
    output logic                 busy
);

    localparam int AW = W + 4;
    localparam int CW = (DV > 1) ? $clog2(DV) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DV - 1);
    // largest magnitude representable in W-bit sign-magnitude
    localparam logic signed [AW-1:0] LIM = {{5{1'b0}}, {(W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic signed [AW-1:0]  acc_q, acc_d, acc_sum;
    logic signed [W-1:0]   buf_q [DV];
    logic                  buf_we;
    logic                  hard_q, hard_d;
    logic                  ov_q, ov_d;
    logic                  last_q, last_d;
    logic [W-1:0]          od_q, od_d;
    logic signed [W-1:0]   msg_tc;
    logic                  msg_xfer, out_xfer;

    // negative zero maps to 0 naturally since -0 == 0
    function automatic logic signed [W-1:0] sm_to_tc(input logic [W-1:0] x);
        logic signed [W-1:0] mag;
        mag = $signed({1'b0, x[W-2:0]});
        return x[W-1] ? -mag : mag;
    endfunction

    function automatic logic signed [AW-1:0] sext(input logic signed [W-1:0] x);
        return $signed({{(AW-W){x[W-1]}}, x});
    endfunction

    function automatic logic [W-1:0] tc_to_sm(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] a;
        logic                 neg;
        neg = v[AW-1];
        a   = neg ? -v : v;
        if (a > LIM) a = LIM;
        return {neg, a[W-2:0]};
    endfunction

    assign msg_tc   = sm_to_tc(bus.msg_data);
    assign acc_sum  = acc_q + sext(msg_tc);
    assign cnt_inc  = cnt_q + 1'b1;
    assign msg_xfer = (state_q == ACCUM) && bus.msg_valid;
    assign out_xfer = ov_q && bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hard_d  = hard_q;
        ov_d    = ov_q;
        last_d  = last_q;
        od_d    = od_q;
        buf_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = sext(sm_to_tc(ch_llr));
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (msg_xfer) begin
                    buf_we = 1'b1;
                    acc_d  = acc_sum;
                    if (cnt_q == LAST_IDX) begin
                        // first output uses the final sum directly; buf_q[0]
                        // is already stored because DV >= 2
                        state_d = EMIT;
                        cnt_d   = '0;
                        hard_d  = acc_sum[AW-1];
                        ov_d    = 1'b1;
                        od_d    = tc_to_sm(acc_sum - sext(buf_q[0]));
                        last_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            EMIT: begin
                if (out_xfer) begin
                    if (last_q) begin
                        state_d = IDLE;
                        ov_d    = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_inc;
                        od_d   = tc_to_sm(acc_q - sext(buf_q[cnt_inc]));
                        last_d = (cnt_inc == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            hard_q  <= 1'b0;
            ov_q    <= 1'b0;
            last_q  <= 1'b0;
            od_q    <= '0;
            for (int i = 0; i < DV; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hard_q  <= hard_d;
            ov_q    <= ov_d;
            last_q  <= last_d;
            od_q    <= od_d;
            if (buf_we) buf_q[cnt_q] <= msg_tc;
        end
    end

    assign bus.msg_ready = (state_q == ACCUM);
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_last  = last_q;
    assign hard_bit      = hard_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_variable_node_unit.sv
module tb_variable_node_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ch_llr = '0;
    logic        hard_bit;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    logic [16:0] sb [$];

    variable_node_unit_if #(.W(16)) ifc ();

    variable_node_unit #(.DV(4), .W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ch_llr   (ch_llr),
        .bus      (ifc.slave),
        .hard_bit (hard_bit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: pop expected {last,data} on every output transfer
    always @(negedge clk) begin
        if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
            logic [16:0] e;
            n_xfer++;
            check("out_xfer_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", 32'(ifc.out_data), 32'(e[15:0]));
                check("out_last", 32'(ifc.out_last), 32'(e[16]));
            end
        end
    end

    // m and e pack four 16-bit words, item k at bits [16k +: 16]
    task automatic run_case(input string tag, input logic [15:0] ch, input logic [63:0] m,
                            input logic [63:0] e, input logic eh, input logic stall,
                            input logic gaps);
        int k;
        int edges;
        int w;
        int x0;
        logic xf;
        for (int i = 0; i < 4; i++) sb.push_back({(i == 3), e[16*i +: 16]});
        x0 = n_xfer;
        @(posedge clk); #1;
        start = 1'b1;
        ch_llr = ch;
        ifc.msg_valid = !gaps;
        ifc.msg_data = m[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        edges = 0;
        while (k < 4 && edges < 40) begin
            @(negedge clk);
            xf = ifc.msg_valid && ifc.msg_ready;
            @(posedge clk); #1;
            edges++;
            if (xf) k++;
            if (k < 4) ifc.msg_data = m[16*k +: 16];
            if (gaps) begin
                ifc.msg_valid = ~ifc.msg_valid;
                start = ~ifc.msg_valid;
            end
        end
        start = 1'b0;
        ifc.msg_valid = 1'b0;
        check({tag, "_msgs_accepted"}, 32'(k), 32'd4);
        @(negedge clk);
        check({tag, "_ov_on_entry"}, 32'(ifc.out_valid), 32'd1);
        check({tag, "_hard_bit"}, 32'(hard_bit), 32'(eh));
        if (!gaps) check({tag, "_latency"}, 32'(edges + 1), 32'd5);
        if (stall) begin
            @(posedge clk); #1;
            ifc.out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check({tag, "_stall_data"}, 32'(ifc.out_data), 32'h0012);
                check({tag, "_stall_valid"}, 32'(ifc.out_valid), 32'd1);
                @(posedge clk); #1;
            end
            ifc.out_ready = 1'b1;
        end
        w = 0;
        while ((sb.size() != 0 || busy) && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        @(negedge clk);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        check({tag, "_xfer_count"}, 32'(n_xfer - x0), 32'd4);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_ov_done"}, 32'(ifc.out_valid), 32'd0);
        check({tag, "_hard_hold"}, 32'(hard_bit), 32'(eh));
        sb.delete();
    endtask

    initial begin
        ifc.msg_valid = 1'b0;
        ifc.msg_data  = '0;
        ifc.out_ready = 1'b1;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_msg_ready", 32'(ifc.msg_ready), 32'd0);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_out_data", 32'(ifc.out_data), 32'd0);
        check("rst_out_last", 32'(ifc.out_last), 32'd0);
        check("rst_hard_bit", 32'(hard_bit), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_case("basic", 16'h000A, 64'h0004_0003_0002_0001, 64'h0010_0011_0012_0013, 1'b0, 1'b0, 1'b0);
        run_case("sat_pos", 16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b0, 1'b0, 1'b0);
        run_case("stall", 16'h000A, 64'h0004_0003_0002_0001, 64'h0010_0011_0012_0013, 1'b0, 1'b1, 1'b0);
        run_case("gaps", 16'h000A, 64'h0004_0003_0002_0001, 64'h0010_0011_0012_0013, 1'b0, 1'b0, 1'b1);
        run_case("sat_neg", 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // abort an update after two accepted messages
        @(posedge clk); #1;
        start = 1'b1;
        ch_llr = 16'h000A;
        ifc.msg_valid = 1'b1;
        ifc.msg_data = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        ifc.msg_data = 16'h0002;
        @(posedge clk); #1;
        ifc.msg_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_msg_ready", 32'(ifc.msg_ready), 32'd0);
        check("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("midrst_out_data", 32'(ifc.out_data), 32'd0);
        check("midrst_out_last", 32'(ifc.out_last), 32'd0);
        check("midrst_hard_bit", 32'(hard_bit), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_out_valid", 32'(ifc.out_valid), 32'd0);

        run_case("signed", 16'h8005, 64'h0000_8001_0002_8003, 64'h8007_8006_8009_8004, 1'b1, 1'b0, 1'b0);
        run_case("negzero", 16'h8000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
